band_sched_ctrl: RTL and testbench



---
 rtl/band_sched_ctrl_pkg.sv | 21 ++
 rtl/band_sched_ctrl_if.sv | 35 +++
 rtl/band_sched_ctrl_slot_tracker.sv | 47 ++++
 rtl/band_sched_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_band_sched_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/band_sched_ctrl_pkg.sv
// Shared types and sizing helpers for the banded image scheduler.
package band_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } top_state_e;

  localparam logic MODE_SERIAL  = 1'b0;
  localparam logic MODE_OVERLAP = 1'b1;

  function automatic int calc_band_len(input int kernel_rows, input int img_cols, input int ch_num);
    return kernel_rows * img_cols * ch_num;
  endfunction

  function automatic int calc_num_bands(input int img_rows, input int kernel_rows);
    return img_rows - kernel_rows + 1;
  endfunction

endpackage

// File: rtl/band_sched_ctrl_if.sv
// Start/abort control plus fetch-side and core-side handshakes of the band scheduler.
interface band_sched_ctrl_if
  import band_sched_pkg::*;
#(
  parameter int ROW_W = 10,
  parameter int LEN_W = 20
);
  logic             start_i;
  logic             abort_i;
  logic             mode_i;
  logic             fetch_done_i;
  logic             fetch_run_o;
  logic [LEN_W-1:0] fetch_len_o;
  logic [ROW_W-1:0] fetch_row_o;
  logic             fetch_slot_o;
  logic             core_done_i;
  logic             core_run_o;
  logic [ROW_W-1:0] core_row_o;
  logic             core_slot_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       state_o;

  modport master (
    output start_i, abort_i, mode_i, fetch_done_i, core_done_i,
    input  fetch_run_o, fetch_len_o, fetch_row_o, fetch_slot_o,
    input  core_run_o, core_row_o, core_slot_o, busy_o, done_o, state_o
  );

  modport slave (
    input  start_i, abort_i, mode_i, fetch_done_i, core_done_i,
    output fetch_run_o, fetch_len_o, fetch_row_o, fetch_slot_o,
    output core_run_o, core_row_o, core_slot_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/band_sched_ctrl_slot_tracker.sv
// Full flags for the two ping-pong band buffer slots; a set and a clear on
// different slots may land on the same edge.
module pingpong_slot_tracker
  import band_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_all,
  input  logic       set_en,
  input  logic       set_slot,
  input  logic       clr_en,
  input  logic       clr_slot,
  output logic [1:0] full
);
  logic [1:0] full_r;
  logic [1:0] full_s;

  // next flag values: frame clear wins, otherwise apply clear then set
  always_comb begin
    full_s = full_r;
    if (clr_all) begin
      full_s = 2'b00;
    end else begin
      if (clr_en) begin
        full_s[clr_slot] = 1'b0;
      end else begin
        full_s[clr_slot] = full_r[clr_slot];
      end
      if (set_en) begin
        full_s[set_slot] = 1'b1;
      end else begin
        full_s[set_slot] = full_s[set_slot];
      end
    end
  end

  // flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 2'b00;
    end else begin
      full_r <= full_s;
    end
  end

  assign full = full_r;
endmodule

// File: rtl/band_sched_ctrl.sv
// Frame-level band scheduler: overlaps BRAM fetch of band k+1 with core processing
// of band k through a two-slot buffer, or strictly alternates in serial mode.
module band_sched_ctrl
  import band_sched_pkg::*;
#(
  parameter int IMG_ROWS    = 540,
  parameter int IMG_COLS    = 540,
  parameter int KERNEL_ROWS = 3,
  parameter int CH_NUM      = 1,
  parameter int ROW_W       = 10,
  parameter int LEN_W       = 20
) (
  input logic              clk,
  input logic              rst,
  band_sched_ctrl_if.slave bus
);
  localparam int BAND_LEN  = calc_band_len(KERNEL_ROWS, IMG_COLS, CH_NUM);
  localparam int NUM_BANDS = calc_num_bands(IMG_ROWS, KERNEL_ROWS);
  localparam logic [ROW_W-1:0] NUM_BANDS_W = ROW_W'(NUM_BANDS);
  localparam logic [ROW_W-1:0] ROW_ONE     = ROW_W'(1);
  localparam logic [LEN_W-1:0] BAND_LEN_W  = LEN_W'(BAND_LEN);

  top_state_e       state_r, state_s;
  logic             mode_r, mode_s;
  logic [ROW_W-1:0] fetch_cnt_r, fetch_cnt_s, core_cnt_r, core_cnt_s;
  logic             fetch_run_r, fetch_run_s, core_run_r, core_run_s;
  logic [LEN_W-1:0] fetch_len_r, fetch_len_s;
  logic [ROW_W-1:0] fetch_row_r, fetch_row_s, core_row_r, core_row_s;
  logic             fetch_slot_r, fetch_slot_s, core_slot_r, core_slot_s;
  logic             busy_r, busy_s, done_r, done_s;
  logic             clr_all_s, set_en_s, clr_en_s;
  logic             fetch_issue_s, core_issue_s;
  logic [1:0]       full_s;

  pingpong_slot_tracker u_slots (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (clr_all_s),
    .set_en   (set_en_s),
    .set_slot (fetch_cnt_r[0]),
    .clr_en   (clr_en_s),
    .clr_slot (core_cnt_r[0]),
    .full     (full_s)
  );

  // Serial mode only fetches into a fully drained buffer with the core idle.
  assign fetch_issue_s = (fetch_cnt_r < NUM_BANDS_W) && !full_s[fetch_cnt_r[0]] && !fetch_run_r &&
                         ((mode_r == MODE_OVERLAP) || ((full_s == 2'b00) && !core_run_r));
  assign core_issue_s  = (core_cnt_r < NUM_BANDS_W) && full_s[core_cnt_r[0]] && !core_run_r;

  // top FSM, fetch/core engines and registered output values
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    fetch_cnt_s = fetch_cnt_r;
    core_cnt_s  = core_cnt_r;
    fetch_run_s = 1'b0;
    core_run_s  = 1'b0;
    clr_all_s   = 1'b0;
    set_en_s    = 1'b0;
    clr_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_s     = ST_RUN;
          mode_s      = bus.mode_i;
          fetch_cnt_s = {ROW_W{1'b0}};
          core_cnt_s  = {ROW_W{1'b0}};
          clr_all_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort_i) begin
          state_s     = ST_IDLE;
          fetch_cnt_s = {ROW_W{1'b0}};
          core_cnt_s  = {ROW_W{1'b0}};
          clr_all_s   = 1'b1;
        end else begin
          if (fetch_run_r) begin
            if (bus.fetch_done_i) begin
              set_en_s    = 1'b1;
              fetch_cnt_s = (fetch_cnt_r < NUM_BANDS_W) ? fetch_cnt_r + ROW_ONE : fetch_cnt_r;
            end else begin
              fetch_run_s = 1'b1;
            end
          end else begin
            fetch_run_s = fetch_issue_s;
          end
          if (core_run_r) begin
            if (bus.core_done_i) begin
              clr_en_s   = 1'b1;
              core_cnt_s = (core_cnt_r < NUM_BANDS_W) ? core_cnt_r + ROW_ONE : core_cnt_r;
            end else begin
              core_run_s = 1'b1;
            end
          end else begin
            core_run_s = core_issue_s;
          end
          if (core_cnt_s == NUM_BANDS_W) begin
            state_s     = ST_DONE;
            fetch_run_s = 1'b0;
            core_run_s  = 1'b0;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort_i) begin
          state_s     = ST_IDLE;
          fetch_cnt_s = {ROW_W{1'b0}};
          core_cnt_s  = {ROW_W{1'b0}};
          clr_all_s   = 1'b1;
        end else if (bus.start_i) begin
          state_s     = ST_RUN;
          mode_s      = bus.mode_i;
          fetch_cnt_s = {ROW_W{1'b0}};
          core_cnt_s  = {ROW_W{1'b0}};
          clr_all_s   = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        fetch_cnt_s = {ROW_W{1'b0}};
        core_cnt_s  = {ROW_W{1'b0}};
        clr_all_s   = 1'b1;
      end
    endcase

    fetch_len_s  = fetch_run_s ? BAND_LEN_W : {LEN_W{1'b0}};
    fetch_row_s  = fetch_run_s ? fetch_cnt_s : {ROW_W{1'b0}};
    fetch_slot_s = fetch_run_s ? fetch_cnt_s[0] : 1'b0;
    core_row_s   = core_run_s ? core_cnt_s : {ROW_W{1'b0}};
    core_slot_s  = core_run_s ? core_cnt_s[0] : 1'b0;
    busy_s       = (state_s == ST_RUN);
    done_s       = (state_s == ST_DONE);
  end

  // state, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_SERIAL;
      fetch_cnt_r  <= {ROW_W{1'b0}};
      core_cnt_r   <= {ROW_W{1'b0}};
      fetch_run_r  <= 1'b0;
      core_run_r   <= 1'b0;
      fetch_len_r  <= {LEN_W{1'b0}};
      fetch_row_r  <= {ROW_W{1'b0}};
      fetch_slot_r <= 1'b0;
      core_row_r   <= {ROW_W{1'b0}};
      core_slot_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      fetch_cnt_r  <= fetch_cnt_s;
      core_cnt_r   <= core_cnt_s;
      fetch_run_r  <= fetch_run_s;
      core_run_r   <= core_run_s;
      fetch_len_r  <= fetch_len_s;
      fetch_row_r  <= fetch_row_s;
      fetch_slot_r <= fetch_slot_s;
      core_row_r   <= core_row_s;
      core_slot_r  <= core_slot_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.fetch_run_o  = fetch_run_r;
  assign bus.fetch_len_o  = fetch_len_r;
  assign bus.fetch_row_o  = fetch_row_r;
  assign bus.fetch_slot_o = fetch_slot_r;
  assign bus.core_run_o   = core_run_r;
  assign bus.core_row_o   = core_row_r;
  assign bus.core_slot_o  = core_slot_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.state_o      = state_r;
endmodule

// File: tb/tb_band_sched_ctrl.sv
// Directed bench for band_sched_ctrl on a 5-row, 4-col, 2-channel image (3 bands of 24 words).
module tb_band_sched_ctrl;
  import band_sched_pkg::*;

  localparam int IMG_ROWS = 5, IMG_COLS = 4, KERNEL_ROWS = 3, CH_NUM = 2;
  localparam int ROW_W = 10, LEN_W = 20;
  localparam int EXP_LEN = 24;
  localparam int F_LAT = 3, C_LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   core0_done_cyc = 0;
  int   ov_end = 0;
  int   serial_cyc = 0;
  int   s, c, d, e;

  band_sched_ctrl_if #(.ROW_W(ROW_W), .LEN_W(LEN_W)) bus ();

  band_sched_ctrl #(
    .IMG_ROWS(IMG_ROWS), .IMG_COLS(IMG_COLS), .KERNEL_ROWS(KERNEL_ROWS),
    .CH_NUM(CH_NUM), .ROW_W(ROW_W), .LEN_W(LEN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, output int at);
    bus.mode_i  = m;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    at = cyc;
  endtask

  task automatic wait_fetch(input int bound, output int seen);
    int k = 0;
    while (bus.fetch_run_o !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    check_val("fetch_wait", 32'(bus.fetch_run_o), 32'd1);
    seen = cyc;
  endtask

  task automatic wait_core(input int bound, output int seen);
    int k = 0;
    while (bus.core_run_o !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    check_val("core_wait", 32'(bus.core_run_o), 32'd1);
    seen = cyc;
  endtask

  task automatic pulse_fetch(input int lat, output int at);
    repeat (lat - 1) step();
    bus.fetch_done_i = 1'b1;
    step();
    bus.fetch_done_i = 1'b0;
    at = cyc;
  endtask

  task automatic pulse_core(input int lat, output int at);
    repeat (lat - 1) step();
    bus.core_done_i = 1'b1;
    step();
    bus.core_done_i = 1'b0;
    at = cyc;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.mode_i = 1'b0;
    bus.fetch_done_i = 1'b0; bus.core_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_state", 32'(bus.state_o), 32'd0);
    check_val("rst_busy", 32'(bus.busy_o), 32'd0);
    check_val("rst_done", 32'(bus.done_o), 32'd0);
    check_val("rst_frun", 32'(bus.fetch_run_o), 32'd0);
    check_val("rst_crun", 32'(bus.core_run_o), 32'd0);
    rst = 1'b0;
    step();

    // first fetch one cycle after start, then asynchronous reset mid-fetch
    do_start(MODE_SERIAL, s);
    check_val("st_run", 32'(bus.state_o), 32'd1);
    check_val("st_busy", 32'(bus.busy_o), 32'd1);
    check_val("st_frun0", 32'(bus.fetch_run_o), 32'd0);
    step();
    check_val("f1_run", 32'(bus.fetch_run_o), 32'd1);
    check_val("f1_row", 32'(bus.fetch_row_o), 32'd0);
    check_val("f1_len", 32'(bus.fetch_len_o), 32'(EXP_LEN));
    #2 rst = 1'b1;
    #1;
    check_val("arst_frun", 32'(bus.fetch_run_o), 32'd0);
    check_val("arst_len", 32'(bus.fetch_len_o), 32'd0);
    check_val("arst_busy", 32'(bus.busy_o), 32'd0);
    check_val("arst_state", 32'(bus.state_o), 32'd0);
    #2 rst = 1'b0;
    step();
    check_val("post_rst_state", 32'(bus.state_o), 32'd0);

    // serial frame: strict fetch/core alternation
    do_start(MODE_SERIAL, s);
    for (int b = 0; b < 3; b++) begin
      wait_fetch(40, c);
      if (b == 0) check_val("ser_first_lat", 32'(c), 32'(s + 1));
      check_val("ser_frow", 32'(bus.fetch_row_o), 32'(b));
      check_val("ser_fslot", 32'(bus.fetch_slot_o), 32'(b % 2));
      check_val("ser_flen", 32'(bus.fetch_len_o), 32'(EXP_LEN));
      check_val("ser_f_nocore", 32'(bus.core_run_o), 32'd0);
      pulse_fetch(F_LAT, d);
      check_val("ser_fdrop", 32'(bus.fetch_run_o), 32'd0);
      wait_core(40, c);
      check_val("ser_core_lat", 32'(c), 32'(d + 1));
      check_val("ser_crow", 32'(bus.core_row_o), 32'(b));
      check_val("ser_cslot", 32'(bus.core_slot_o), 32'(b % 2));
      check_val("ser_c_nofetch", 32'(bus.fetch_run_o), 32'd0);
      pulse_core(C_LAT, e);
    end
    check_val("ser_done", 32'(bus.done_o), 32'd1);
    check_val("ser_busy", 32'(bus.busy_o), 32'd0);
    check_val("ser_state", 32'(bus.state_o), 32'd2);
    serial_cyc = e - s;

    // start while DONE goes straight to RUN in overlap mode
    do_start(MODE_OVERLAP, s);
    check_val("rs_state", 32'(bus.state_o), 32'd1);
    check_val("rs_done", 32'(bus.done_o), 32'd0);
    check_val("rs_frow", 32'(bus.fetch_row_o), 32'd0);
    fork
      begin
        int fc, fd;
        for (int b = 0; b < 3; b++) begin
          wait_fetch(40, fc);
          check_val("ov_frow", 32'(bus.fetch_row_o), 32'(b));
          check_val("ov_fslot", 32'(bus.fetch_slot_o), 32'(b % 2));
          if (b == 2) check_val("ov_f2_stall", 32'(fc), 32'(core0_done_cyc + 1));
          pulse_fetch(F_LAT, fd);
        end
      end
      begin
        int cc, ce;
        for (int b = 0; b < 3; b++) begin
          wait_core(40, cc);
          check_val("ov_crow", 32'(bus.core_row_o), 32'(b));
          check_val("ov_cslot", 32'(bus.core_slot_o), 32'(b % 2));
          if (b == 0) begin
            check_val("ov_overlap_run", 32'(bus.fetch_run_o), 32'd1);
            check_val("ov_overlap_row", 32'(bus.fetch_row_o), 32'd1);
          end
          pulse_core(C_LAT, ce);
          if (b == 0) core0_done_cyc = ce;
          ov_end = ce;
        end
      end
    join
    check_val("ov_done", 32'(bus.done_o), 32'd1);
    check_val("ov_faster", 32'((ov_end - s) < serial_cyc), 32'd1);

    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check_val("abd_state", 32'(bus.state_o), 32'd0);
    check_val("abd_done", 32'(bus.done_o), 32'd0);

    // spurious done pulses while both runs are low are ignored
    do_start(MODE_OVERLAP, s);
    bus.fetch_done_i = 1'b1; bus.core_done_i = 1'b1;
    step();
    bus.fetch_done_i = 1'b0; bus.core_done_i = 1'b0;
    check_val("sp_frun", 32'(bus.fetch_run_o), 32'd1);
    check_val("sp_frow", 32'(bus.fetch_row_o), 32'd0);
    check_val("sp_crun", 32'(bus.core_run_o), 32'd0);
    bus.fetch_done_i = 1'b1;
    step();
    bus.fetch_done_i = 1'b0;
    check_val("sd_f0_drop", 32'(bus.fetch_run_o), 32'd0);
    check_val("sd_c0_idle", 32'(bus.core_run_o), 32'd0);
    step();
    check_val("sd_c0_run", 32'(bus.core_run_o), 32'd1);
    check_val("sd_c0_row", 32'(bus.core_row_o), 32'd0);
    check_val("sd_f1_run", 32'(bus.fetch_run_o), 32'd1);
    check_val("sd_f1_row", 32'(bus.fetch_row_o), 32'd1);
    check_val("sd_f1_slot", 32'(bus.fetch_slot_o), 32'd1);

    // fetch row 1 and core row 0 complete on the same edge
    bus.fetch_done_i = 1'b1; bus.core_done_i = 1'b1;
    step();
    bus.fetch_done_i = 1'b0; bus.core_done_i = 1'b0;
    check_val("sd_both_fdrop", 32'(bus.fetch_run_o), 32'd0);
    check_val("sd_both_cdrop", 32'(bus.core_run_o), 32'd0);
    step();
    check_val("sd_c1_run", 32'(bus.core_run_o), 32'd1);
    check_val("sd_c1_row", 32'(bus.core_row_o), 32'd1);
    check_val("sd_c1_slot", 32'(bus.core_slot_o), 32'd1);
    check_val("sd_f2_run", 32'(bus.fetch_run_o), 32'd1);
    check_val("sd_f2_row", 32'(bus.fetch_row_o), 32'd2);
    check_val("sd_f2_slot", 32'(bus.fetch_slot_o), 32'd0);

    // abort during the second core pass
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check_val("ab_crun", 32'(bus.core_run_o), 32'd0);
    check_val("ab_frun", 32'(bus.fetch_run_o), 32'd0);
    check_val("ab_state", 32'(bus.state_o), 32'd0);
    check_val("ab_done", 32'(bus.done_o), 32'd0);
    step();
    check_val("ab_done_hold", 32'(bus.done_o), 32'd0);
    do_start(MODE_SERIAL, s);
    step();
    check_val("ab_restart_run", 32'(bus.fetch_run_o), 32'd1);
    check_val("ab_restart_row", 32'(bus.fetch_row_o), 32'd0);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
